mod_updown_counter: RTL and testbench

//  Parametrised modulo-N up/down counter with synchronous clear, parallel load, enable,
//  and wrap/saturate mode. Supersedes the fixed 4-bit up counter in battleship: shot/turn

---
 rtl/mod_updown_counter_pkg.sv | 27 ++
 rtl/mod_updown_counter_counter_reg.sv | 27 ++
 rtl/mod_updown_counter.sv | 125 ++++++++++++
 tb/tb_mod_updown_counter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mod_updown_counter_pkg.sv
// Shared definitions for the modulo-N up/down counter.
//   CNT_UP / CNT_DN     : values for the up (direction) input
//   CNT_SAT / CNT_WRAP  : values for the sat (boundary mode) input
//   cnt_op_e            : the single action taken on a clock edge
//   decode_op           : resolves clr > load > en priority into one action
package mod_updown_counter_pkg;

   localparam logic CNT_UP   = 1'b1;
   localparam logic CNT_DN   = 1'b0;
   localparam logic CNT_SAT  = 1'b1;
   localparam logic CNT_WRAP = 1'b0;

   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_CLR  = 2'd1,
      OP_LOAD = 2'd2,
      OP_STEP = 2'd3
   } cnt_op_e;

   function automatic cnt_op_e decode_op(input logic i_clr, input logic i_load, input logic i_en);
      if (i_clr)       return OP_CLR;
      else if (i_load) return OP_LOAD;
      else if (i_en)   return OP_STEP;
      else             return OP_HOLD;
   endfunction

endpackage

// File: rtl/mod_updown_counter_counter_reg.sv
// counter_reg: WIDTH-bit storage register for the counter value.
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset, forces o_q to RST_VAL
//   i_load  : when high, o_q takes i_d on the clock edge; otherwise holds
//   i_d     : next value
//   o_q     : registered value
module counter_reg #(
   parameter int WIDTH   = 4,
   parameter int RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        r_q <= WIDTH'(RST_VAL);
      else if (i_load) r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-(MAX+1) up/down counter with synchronous clear,
// clamped parallel load, enable, and wrap/saturate boundary handling.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset (out=RST_VAL, wrap=0, ovf=0)
//   clr      : synchronous clear (highest priority)
//   load     : synchronous load of min(load_val, MAX)
//   load_val : load data
//   en       : count enable (lowest priority)
//   up       : 1 = increment, 0 = decrement
//   sat      : 1 = hold at boundary, 0 = wrap
//   out      : registered count, always 0..MAX
//   tc       : combinational terminal count for the current direction
//   wrap     : registered one-cycle pulse after a wrap step
//   ovf      : registered sticky flag, set by any enabled step at the boundary
module mod_updown_counter
   import mod_updown_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MAX     = 15,
   parameter int RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   input  logic             sat,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   if (WIDTH < 1 || MAX < 0 || (MAX >> WIDTH) != 0 || RST_VAL < 0 || RST_VAL > MAX) begin : g_bad_params
      $error("mod_updown_counter: illegal WIDTH/MAX/RST_VAL combination");
   end

   // Arithmetic is done one bit wider so that MAX = 2**WIDTH-1 still sees the
   // carry/borrow instead of silently rolling over.
   localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX);
   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);

   cnt_op_e          w_op;
   logic [WIDTH-1:0] w_cnt;
   logic [WIDTH-1:0] w_next;
   logic             w_reg_load;
   logic [WIDTH:0]   w_inc;
   logic [WIDTH:0]   w_dec;
   logic [WIDTH:0]   w_ld_ext;
   logic [WIDTH-1:0] w_ld_clamp;
   logic             w_wrap_next;
   logic             w_ovf_next;
   logic             r_wrap;
   logic             r_ovf;

   assign w_op       = decode_op(clr, load, en);
   assign w_inc      = {1'b0, w_cnt} + (WIDTH+1)'(1);
   assign w_dec      = {1'b0, w_cnt} - (WIDTH+1)'(1);
   assign w_ld_ext   = {1'b0, load_val};
   assign w_ld_clamp = (w_ld_ext > MAX_EXT) ? MAX_V : load_val;
   assign tc         = up ? (w_cnt == MAX_V) : (w_cnt == '0);

   always_comb begin
      w_next      = w_cnt;
      w_reg_load  = 1'b0;
      w_wrap_next = 1'b0;
      w_ovf_next  = r_ovf;
      case (w_op)
         OP_CLR: begin
            w_next     = '0;
            w_reg_load = 1'b1;
            w_ovf_next = 1'b0;
         end
         OP_LOAD: begin
            w_next     = w_ld_clamp;
            w_reg_load = 1'b1;
         end
         OP_STEP: begin
            if (!tc) begin
               w_next     = up ? w_inc[WIDTH-1:0] : w_dec[WIDTH-1:0];
               w_reg_load = 1'b1;
            end else begin
               w_ovf_next = 1'b1;
               if (!sat) begin
                  // Boundary detected from the widened result: carry past MAX
                  // or borrow below zero selects the opposite end of the range.
                  w_next      = up ? ((w_inc > MAX_EXT) ? '0 : w_inc[WIDTH-1:0])
                                   : (w_dec[WIDTH] ? MAX_V : w_dec[WIDTH-1:0]);
                  w_reg_load  = 1'b1;
                  w_wrap_next = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   counter_reg #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
   ) u_counter_reg (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_reg_load),
      .i_d    (w_next),
      .o_q    (w_cnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrap <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_wrap <= w_wrap_next;
         r_ovf  <= w_ovf_next;
      end
   end

   assign out  = w_cnt;
   assign wrap = r_wrap;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: a WIDTH=4/MAX=9 instance and a WIDTH=3/MAX=7
// instance share stimulus; both are compared every cycle to a behavioural model.
module tb_mod_updown_counter;
   import mod_updown_counter_pkg::*;

   logic       clk = 1'b0;
   logic       rst, clr, load, en, up, sat;
   logic [3:0] load_val;
   logic [2:0] load_val2;
   logic [3:0] out1;
   logic [2:0] out2;
   logic       tc1, wrap1, ovf1, tc2, wrap2, ovf2;

   int tests = 0;
   int fails = 0;

   int m_cnt  [2];
   int m_wrap [2];
   int m_ovf  [2];

   assign load_val2 = load_val[2:0];

   always #5 clk = ~clk;

   mod_updown_counter #(.WIDTH(4), .MAX(9), .RST_VAL(0)) dut1 (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up(up), .sat(sat), .out(out1), .tc(tc1), .wrap(wrap1), .ovf(ovf1)
   );

   mod_updown_counter #(.WIDTH(3), .MAX(7), .RST_VAL(0)) dut2 (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val2),
      .en(en), .up(up), .sat(sat), .out(out2), .tc(tc2), .wrap(wrap2), .ovf(ovf2)
   );

   function automatic int max_of(input int i);
      return (i == 0) ? 9 : 7;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_rst();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i]  = 0;
         m_wrap[i] = 0;
         m_ovf[i]  = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         int mx, lv;
         bit at_edge;
         mx = max_of(i);
         lv = (i == 0) ? int'(load_val) : int'(load_val2);
         if (clr) begin
            m_cnt[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
         end else if (load) begin
            m_cnt[i] = (lv > mx) ? mx : lv; m_wrap[i] = 0;
         end else if (en) begin
            at_edge = up ? (m_cnt[i] == mx) : (m_cnt[i] == 0);
            if (!at_edge) begin
               m_cnt[i] = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
               m_wrap[i] = 0;
            end else begin
               m_ovf[i] = 1;
               if (sat == CNT_WRAP) begin
                  m_cnt[i] = up ? 0 : mx;
                  m_wrap[i] = 1;
               end else begin
                  m_wrap[i] = 0;
               end
            end
         end else begin
            m_wrap[i] = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      int exp_tc [2];
      for (int i = 0; i < 2; i++)
         exp_tc[i] = ((up && m_cnt[i] == max_of(i)) || (!up && m_cnt[i] == 0)) ? 1 : 0;
      chk({tag, "_out1"},  32'(out1),  32'(m_cnt[0]));
      chk({tag, "_wrap1"}, 32'(wrap1), 32'(m_wrap[0]));
      chk({tag, "_ovf1"},  32'(ovf1),  32'(m_ovf[0]));
      chk({tag, "_tc1"},   32'(tc1),   32'(exp_tc[0]));
      chk({tag, "_out2"},  32'(out2),  32'(m_cnt[1]));
      chk({tag, "_wrap2"}, 32'(wrap2), 32'(m_wrap[1]));
      chk({tag, "_ovf2"},  32'(ovf2),  32'(m_ovf[1]));
      chk({tag, "_tc2"},   32'(tc2),   32'(exp_tc[1]));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (rst) model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      rst = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b1;
      up = CNT_UP; sat = CNT_WRAP; load_val = 4'd0;
      model_rst();
      #1;
      check_all("reset");

      // reset held with en=1, then release and count
      for (int k = 0; k < 4; k++) tick("t1_rst");
      rst = 1'b1;
      for (int k = 0; k < 3; k++) tick("t1_cnt");
      chk("t1_out_is_3", 32'(out1), 32'd3);

      // up wrap over 12 edges
      clr = 1'b1; tick("t2_clr"); clr = 1'b0;
      for (int k = 0; k < 12; k++) tick("t2_up");
      chk("t2_final_out", 32'(out1), 32'd2);
      chk("t2_final_ovf", 32'(ovf1), 32'd1);

      // load 2, count down saturating
      clr = 1'b1; tick("t3_clr"); clr = 1'b0;
      up = CNT_DN; sat = CNT_SAT; load_val = 4'd2; load = 1'b1;
      tick("t3_load"); load = 1'b0;
      for (int k = 0; k < 4; k++) tick("t3_dn");
      chk("t3_sat_out", 32'(out1), 32'd0);
      chk("t3_sat_ovf", 32'(ovf1), 32'd1);

      // clr beats load beats en; load clamps
      clr = 1'b1; load = 1'b1; load_val = 4'd7;
      tick("t4_prio"); clr = 1'b0;
      chk("t4_prio_out", 32'(out1), 32'd0);
      load_val = 4'd13;
      tick("t4_clamp"); load = 1'b0;
      chk("t4_clamp_out", 32'(out1), 32'd9);

      // asynchronous reset between edges
      load_val = 4'd5; load = 1'b1; up = CNT_UP; sat = CNT_WRAP;
      tick("t5_load"); load = 1'b0;
      tick("t5_step");
      chk("t5_mid_out", 32'(out1), 32'd6);
      #2 rst = 1'b0;
      #1 model_rst();
      check_all("t5_async");
      chk("t5_async_out", 32'(out1), 32'd0);
      tick("t5_held");
      rst = 1'b1;

      // 3-bit instance natural rollover 7 -> 0
      clr = 1'b1; tick("t5b_clr"); clr = 1'b0;
      for (int k = 0; k < 8; k++) tick("t5b_up");
      chk("t5b_out2", 32'(out2), 32'd0);
      chk("t5b_wrap2", 32'(wrap2), 32'd1);

      // direction flip at the boundaries
      load_val = 4'd9; load = 1'b1;
      tick("t6_load"); load = 1'b0;
      for (int k = 0; k < 4; k++) begin
         up = (k % 2 == 0) ? CNT_UP : CNT_DN;
         #1 check_all("t6_tc");
         tick("t6_flip");
         chk("t6_wrap1", 32'(wrap1), 32'd1);
      end

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         clr      = ($urandom_range(15) == 0);
         load     = ($urandom_range(7) == 0);
         en       = ($urandom_range(3) != 0);
         up       = $urandom_range(1) != 0;
         sat      = $urandom_range(1) != 0;
         load_val = 4'($urandom_range(15));
         if ($urandom_range(63) == 0) begin
            rst = 1'b0;
            #1 model_rst();
            check_all("rnd_async");
            rst = 1'b1;
         end
         tick("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
